// File: rtl/uart_tx.sv
// uart_tx: UART serializer paced by an oversampling tick (start, DBIT data LSB first, stop).
// Optional even-parity bit between data and stop when UART_TX_PARITY_EN is defined.
module uart_tx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int OS_TICK = 16
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_tick,
  input  logic            i_tx_start,
  input  logic [DBIT-1:0] i_data_byte,
  output logic            o_tx,
  output logic            o_tx_busy,
  output logic            o_done_bit
);
  localparam int TMAX = (OS_TICK > SB_TICK) ? OS_TICK : SB_TICK;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int BW   = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [TW-1:0] OS_LAST  = TW'(OS_TICK - 1);
  localparam logic [TW-1:0] SB_LAST  = TW'(SB_TICK - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DBIT - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t          state, state_nx;
  logic [TW-1:0]   tick_cnt, tick_nx;
  logic [BW-1:0]   bit_cnt, bit_nx;
  logic [DBIT-1:0] shift_reg, shift_nx;
  logic            tx_nx, busy_nx, done_nx;
  logic            accept;

  // The done cycle blocks acceptance so a new frame always sees one idle clock.
  assign accept = (state == IDLE) && i_tx_start && !o_done_bit;

`ifdef UART_TX_PARITY_EN
  logic parity_q;

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      parity_q <= 1'b0;
    end else if (accept) begin
      parity_q <= ^i_data_byte;
    end
  end
`endif

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      o_tx       <= 1'b1;
      o_tx_busy  <= 1'b0;
      o_done_bit <= 1'b0;
    end else begin
      state      <= state_nx;
      tick_cnt   <= tick_nx;
      bit_cnt    <= bit_nx;
      shift_reg  <= shift_nx;
      o_tx       <= tx_nx;
      o_tx_busy  <= busy_nx;
      o_done_bit <= done_nx;
    end
  end

  always_comb begin
    state_nx = state;
    tick_nx  = tick_cnt;
    bit_nx   = bit_cnt;
    shift_nx = shift_reg;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx = START;
          tick_nx  = '0;
          bit_nx   = '0;
          shift_nx = i_data_byte;
        end
      end
      START: begin
        if (i_tick) begin
          if (tick_cnt == OS_LAST) begin
            state_nx = DATA;
            tick_nx  = '0;
            bit_nx   = '0;
          end else begin
            tick_nx = tick_cnt + TW'(1);
          end
        end
      end
      DATA: begin
        if (i_tick) begin
          if (tick_cnt == OS_LAST) begin
            tick_nx  = '0;
            shift_nx = shift_reg >> 1;
            if (bit_cnt == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_nx = PARITY;
`else
              state_nx = STOP;
`endif
            end else begin
              bit_nx = bit_cnt + BW'(1);
            end
          end else begin
            tick_nx = tick_cnt + TW'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (i_tick) begin
          if (tick_cnt == OS_LAST) begin
            state_nx = STOP;
            tick_nx  = '0;
          end else begin
            tick_nx = tick_cnt + TW'(1);
          end
        end
      end
`endif
      STOP: begin
        if (i_tick) begin
          if (tick_cnt == SB_LAST) begin
            state_nx = IDLE;
            tick_nx  = '0;
          end else begin
            tick_nx = tick_cnt + TW'(1);
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Line level follows the current state, giving one clock of latency after acceptance.
  always_comb begin
    tx_nx = 1'b1;
    case (state)
      START:   tx_nx = 1'b0;
      DATA:    tx_nx = shift_reg[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_nx = parity_q;
`endif
      default: tx_nx = 1'b1;
    endcase
    busy_nx = (state_nx != IDLE);
    done_nx = (state == STOP) && (state_nx == IDLE);
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: random and directed frames; a line monitor decodes each frame and checks it
// against bytes queued by the stimulus. Define UART_TX_PARITY_EN to match a parity build.
module tb_uart_tx;
  localparam int DBIT = 8;
  localparam int OS   = 16;
  localparam int SB   = 16;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME_TICKS = OS * (1 + DBIT + PAR) + SB;
  localparam int NBITS       = 2 + DBIT + PAR;

  logic            i_clock = 1'b0;
  logic            i_reset = 1'b0;
  logic            i_tick = 1'b0;
  logic            i_tx_start = 1'b0;
  logic [DBIT-1:0] i_data_byte = '0;
  logic            o_tx, o_tx_busy, o_done_bit;

  int total = 0;
  int bad = 0;
  logic [DBIT-1:0] exp_q[$];

  uart_tx #(.DBIT(DBIT), .SB_TICK(SB), .OS_TICK(OS)) dut (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .i_tick(i_tick),
    .i_tx_start(i_tx_start),
    .i_data_byte(i_data_byte),
    .o_tx(o_tx),
    .o_tx_busy(o_tx_busy),
    .o_done_bit(o_done_bit)
  );

  initial forever #5 i_clock = ~i_clock;

  // One tick every fourth clock, changed on the falling edge.
  int tick_phase = 0;
  initial forever begin
    @(negedge i_clock);
    tick_phase = (tick_phase + 1) % 4;
    i_tick = (tick_phase == 0);
  end

  initial begin
    #(10 * 80000);
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected line levels of one frame, bit 0 = start bit.
  function automatic int frame_of(input logic [DBIT-1:0] b);
    int ones;
    int f;
    ones = 0;
    f = 0;
    for (int i = 0; i < DBIT; i++) begin
      if (b[i]) begin
        ones++;
        f += (1 << (1 + i));
      end
    end
    if (PAR == 1 && (ones % 2) == 1) f += (1 << (1 + DBIT));
    f += (1 << (NBITS - 1));
    return f;
  endfunction

  // Monitor: acts as a receiver on o_tx, sampling each bit at its mid-point tick.
  logic in_frame = 1'b0;
  logic prev_tx = 1'b1;
  logic prev_done = 1'b0;
  logic busy_ok = 1'b1;
  int   ticks = 0;
  int   got = 0;

  initial forever begin
    @(posedge i_clock);
    #1;
    if (!i_reset) begin
      in_frame = 1'b0;
    end else begin
      if (in_frame) begin
        if (i_tick) begin
          ticks++;
          if ((ticks % OS) == OS / 2 && (ticks / OS) < NBITS && o_tx)
            got += (1 << (ticks / OS));
        end
        if (!o_done_bit && !o_tx_busy) busy_ok = 1'b0;
      end
      if (o_done_bit) begin
        check("done_single_cycle", int'(prev_done), 0);
        if (!in_frame || exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done pulse, expected none (in_frame=%0b queued=%0d)",
                   in_frame, exp_q.size());
        end else begin
          logic [DBIT-1:0] b;
          b = exp_q.pop_front();
          check("frame_bits", got, frame_of(b));
          check("frame_ticks", ticks, FRAME_TICKS);
          check("busy_during_frame", int'(busy_ok), 1);
        end
        in_frame = 1'b0;
      end else if (!in_frame && prev_tx && !o_tx) begin
        in_frame = 1'b1;
        ticks = i_tick ? 1 : 0;
        got = 0;
        busy_ok = 1'b1;
      end
    end
    prev_tx = o_tx;
    prev_done = o_done_bit;
  end

  task automatic step();
    @(negedge i_clock);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((o_tx_busy || o_done_bit) && n < 3000) begin
      step();
      n++;
    end
    if (n >= 3000) begin
      total++;
      bad++;
      $display("FAIL wait_idle: still busy=%0b after %0d cycles, expected idle", o_tx_busy, n);
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!o_done_bit && n < 3000) begin
      step();
      n++;
    end
    if (n >= 3000) begin
      total++;
      bad++;
      $display("FAIL wait_done: no done pulse within %0d cycles, expected one", n);
    end
  endtask

  task automatic wait_ticks(input int cnt);
    int c;
    c = 0;
    while (c < cnt) begin
      step();
      if (i_tick) c++;
    end
  endtask

  task automatic send(input logic [DBIT-1:0] b, input bit push, input bit aligned);
    wait_idle();
    if (aligned) begin
      int n;
      n = 0;
      while (!i_tick && n < 8) begin
        step();
        n++;
      end
    end
    i_data_byte = b;
    i_tx_start = 1'b1;
    if (push) exp_q.push_back(b);
    step();
    i_tx_start = 1'b0;
  endtask

  initial begin
    i_reset = 1'b0;
    repeat (3) step();
    check("reset_tx", int'(o_tx), 1);
    check("reset_busy", int'(o_tx_busy), 0);
    check("reset_done", int'(o_done_bit), 0);
    i_reset = 1'b1;
    step();

    send(8'h55, 1'b1, 1'b0);

    // Start request mid-frame must be ignored.
    send(8'hA3, 1'b1, 1'b0);
    wait_ticks(40);
    i_data_byte = 8'hFF;
    i_tx_start = 1'b1;
    step();
    i_tx_start = 1'b0;

    // Back to back: start held through the done cycle with a decoy byte, then FF accepted.
    send(8'h00, 1'b1, 1'b0);
    wait_done();
    i_data_byte = 8'h5A;
    i_tx_start = 1'b1;
    step();
    i_data_byte = 8'hFF;
    exp_q.push_back(8'hFF);
    step();
    i_tx_start = 1'b0;

    // Reset mid-frame aborts with no done pulse.
    send(8'h3C, 1'b0, 1'b0);
    wait_ticks(70);
    i_reset = 1'b0;
    step();
    check("abort_tx", int'(o_tx), 1);
    check("abort_busy", int'(o_tx_busy), 0);
    check("abort_done", int'(o_done_bit), 0);
    i_reset = 1'b1;
    send(8'h3C, 1'b1, 1'b0);

    send(8'h07, 1'b1, 1'b1);

    for (int k = 0; k < 10; k++) begin
      send(DBIT'($urandom), 1'b1, k[0]);
      repeat ($urandom_range(1, 100)) step();
      i_data_byte = DBIT'($urandom);
      i_tx_start = 1'b1;
      step();
      i_tx_start = 1'b0;
      i_data_byte = DBIT'($urandom);
      repeat ($urandom_range(0, 10)) step();
    end

    begin
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 5000) begin
        step();
        n++;
      end
    end
    repeat (20) step();
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
